digi_ota_decimator: RTL



---
 rtl/digi_ota_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/digi_ota_decimator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/digi_ota_pkg.sv
// Purpose: shared types and defaults for the digital OTA decimator slice.
// Contents: FSM state enum, default window/settle parameters, and the
//           result-width helper (a window of all ones must fit).
package digi_ota_pkg;

    localparam int unsigned WIN_LOG2_DEF = 8;
    localparam int unsigned SETTLE_DEF   = 4;
    localparam int unsigned SET_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2
    } state_e;

    // Result width: count of 2^win_log2 ones needs one extra bit.
    function automatic int unsigned out_width(input int unsigned win_log2);
        return win_log2 + 1;
    endfunction

    localparam int unsigned OUT_W_DEF = out_width(WIN_LOG2_DEF);

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, flops clear to 0
//   d_i  - asynchronous input
//   q_o  - synchronised output (two clk edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/digi_ota_decimator.sv
// Purpose: synchronise the OTA comparator bit, count ones over a 2^WIN_LOG2
//          window (boxcar decimation) and present each count over valid/ready.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   en_i       - run enable (level)
//   cmp_i      - asynchronous comparator bit
//   out_data   - ones count of the last completed window
//   out_valid  - out_data holds an unconsumed result
//   out_ready  - consumer accepts when out_valid && out_ready at a rising edge
//   overrun    - sticky: a completed window was dropped
//   busy       - high while settling or accumulating
module digi_ota_decimator
    import digi_ota_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
    parameter int unsigned SETTLE   = SETTLE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          cmp_i,
    output logic [out_width(WIN_LOG2)-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
    output logic                          busy
);

    localparam int unsigned OUT_W = out_width(WIN_LOG2);

    logic                s_cmp;
    state_e              state_q, state_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;
    logic                accept_c;
    logic [OUT_W-1:0]    sum_c;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (cmp_i),
        .q_o (s_cmp)
    );

    assign accept_c = out_valid_q && out_ready;
    assign sum_c    = acc_q + OUT_W'(s_cmp);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            set_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            set_q       <= set_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: run control, window accumulation and output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        set_d       = set_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        // A consumed result frees the register; a new load below overrides.
        if (accept_c) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d   = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                    cnt_d     = '0;
                    set_d     = '0;
                    acc_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    set_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (set_q == SET_W'(SETTLE - 1)) begin
                    state_d = ST_ACCUM;
                    set_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            ST_ACCUM: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q + WIN_LOG2'(1);
                    if (cnt_q == {WIN_LOG2{1'b1}}) begin
                        // Window complete: the last sample is folded in here,
                        // and the next window starts with no gap.
                        acc_d = '0;
                        if (!out_valid_q || accept_c) begin
                            out_data_d  = sum_c;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        acc_d = sum_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
